// File: rtl/adder_bist.sv
// Built-in self test for a 16-bit combinational adder. Pseudo-random operands
// from a 32-bit LFSR drive the adder; each returned sum is compared against a
// golden sum that was registered along with the operands.
module adder_bist #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_vec,
  output logic [15:0] dut_a,
  output logic [15:0] dut_b,
  output logic        dut_cin,
  input  logic [15:0] dut_sum,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail,
  output logic [1:0]  state_dbg
);

  // Handshake: start is a level that is sampled only in IDLE or DONE, together
  // with num_vec; there is no ready/acknowledge, and start seen in RUN is dropped.

  // A zero LFSR state would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'h0000_0001 : SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q;
  logic [15:0] index_q;
  logic [15:0] num_lat_q;
  logic [16:0] golden_q;

  logic        load_run;
  logic        zero_run;
  logic        step;
  logic        last_vec;
  logic        mismatch;
  logic [31:0] lfsr_next;
  logic [15:0] idx_next;
  logic [16:0] seed_gold;
  logic [16:0] next_gold;

  assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign idx_next  = index_q + 16'd1;
  assign seed_gold = {1'b0, SEED_EFF[31:16]} + {1'b0, SEED_EFF[15:0]};
  assign next_gold = {1'b0, lfsr_next[31:16]} + {1'b0, lfsr_next[15:0]} + {16'd0, idx_next[0]};
  assign last_vec  = (index_q == (num_lat_q - 16'd1));
  assign mismatch  = ({dut_cout, dut_sum} != golden_q);

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_count == 16'd0);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_d  = state_q;
    load_run = 1'b0;
    zero_run = 1'b0;
    step     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (num_vec != 16'd0) begin
            state_d  = S_RUN;
            load_run = 1'b1;
          end else begin
            state_d  = S_DONE;
            zero_run = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (last_vec) state_d = S_DONE;
        else          step    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Vector generation, golden registration and result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q     <= SEED_EFF;
      dut_a      <= 16'd0;
      dut_b      <= 16'd0;
      dut_cin    <= 1'b0;
      golden_q   <= 17'd0;
      index_q    <= 16'd0;
      num_lat_q  <= 16'd0;
      err_count  <= 16'd0;
      first_fail <= 16'hFFFF;
    end else if (load_run) begin
      lfsr_q     <= SEED_EFF;
      dut_a      <= SEED_EFF[31:16];
      dut_b      <= SEED_EFF[15:0];
      dut_cin    <= 1'b0;
      golden_q   <= seed_gold;
      index_q    <= 16'd0;
      num_lat_q  <= num_vec;
      err_count  <= 16'd0;
      first_fail <= 16'hFFFF;
    end else if (zero_run) begin
      err_count  <= 16'd0;
      first_fail <= 16'hFFFF;
    end else if (state_q == S_RUN) begin
      if (mismatch) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (first_fail == 16'hFFFF) first_fail <= index_q;
      end
      if (step) begin
        lfsr_q   <= lfsr_next;
        dut_a    <= lfsr_next[31:16];
        dut_b    <= lfsr_next[15:0];
        dut_cin  <= idx_next[0];
        golden_q <= next_gold;
        index_q  <= idx_next;
      end
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist with a behavioural adder that can inject faults.
module tb_adder_bist;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] dut_a;
  logic [15:0] dut_b;
  logic        dut_cin;
  logic [15:0] dut_sum;
  logic        dut_cout;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_fail;
  logic [1:0]  state_dbg;

  int checks;
  int failures;
  int fault_mode;

  // First eight vectors for SEED=1, worked by hand from the LFSR taps.
  logic [15:0] exp_b [0:7];
  logic [15:0] obs_a [0:7];
  logic [15:0] obs_b [0:7];
  logic        obs_cin [0:7];

  adder_bist #(.SEED(32'h0000_0001)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vec    (num_vec),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_cin    (dut_cin),
    .dut_sum    (dut_sum),
    .dut_cout   (dut_cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .state_dbg  (state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test: 0 ideal, 1 sum[0] stuck at 0, 2 always wrong,
  // 3 wrong only when B == 16'h000D (vector 3).
  always_comb begin
    logic [16:0] s;
    s = {1'b0, dut_a} + {1'b0, dut_b} + {16'd0, dut_cin};
    case (fault_mode)
      1: s[0] = 1'b0;
      2: s[0] = ~s[0];
      3: if (dut_b == 16'h000D) s[8] = ~s[8];
      default: ;
    endcase
    {dut_cout, dut_sum} = s;
  end

  // Issue start and wait for done; records the first eight driven vectors.
  task automatic run_to_done(input logic [15:0] n, output int cyc, output int busy_cyc);
    int bound;
    bound = int'(n) + 10;
    start   = 1'b1;
    num_vec = n;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    busy_cyc = 0;
    while (!done && cyc < bound) begin
      if (busy) begin
        if (busy_cyc < 8) begin
          obs_a[busy_cyc]   = dut_a;
          obs_b[busy_cyc]   = dut_b;
          obs_cin[busy_cyc] = dut_cin;
        end
        busy_cyc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; num_vec = 16'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_a !== 16'd0 || dut_b !== 16'd0 || dut_cin !== 1'b0) begin
      failures++; $display("FAIL reset_vec: a=%h b=%h cin=%b expected 0/0/0", dut_a, dut_b, dut_cin);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || state_dbg !== 2'd0) begin
      failures++; $display("FAIL reset_flags: busy=%b done=%b pass=%b st=%0d expected 0/0/0/0", busy, done, pass, state_dbg);
    end
    checks++;
    if (err_count !== 16'd0 || first_fail !== 16'hFFFF) begin
      failures++; $display("FAIL reset_results: err=%h ff=%h expected 0000/ffff", err_count, first_fail);
    end
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      failures++; $display("FAIL reset_idle: busy=%b st=%0d expected 0/0", busy, state_dbg);
    end
  endtask

  task automatic test_basic();
    int cyc, bc;
    fault_mode = 0;
    run_to_done(16'd4, cyc, bc);
    checks++;
    if (cyc !== 5 || done !== 1'b1) begin
      failures++; $display("FAIL basic_done_time: cycles=%0d done=%b expected 5/1", cyc, done);
    end
    checks++;
    if (bc !== 4) begin
      failures++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_a[k] !== 16'h0000 || obs_b[k] !== exp_b[k] || obs_cin[k] !== k[0]) begin
        failures++;
        $display("FAIL basic_vec%0d: a=%h b=%h cin=%b expected 0000/%h/%b", k, obs_a[k], obs_b[k], obs_cin[k], exp_b[k], k[0]);
      end
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'd0 || first_fail !== 16'hFFFF) begin
      failures++; $display("FAIL basic_result: pass=%b err=%h ff=%h expected 1/0000/ffff", pass, err_count, first_fail);
    end
  endtask

  task automatic test_stuck_bit0();
    int cyc, bc;
    fault_mode = 1;
    run_to_done(16'd8, cyc, bc);
    for (int k = 4; k < 8; k++) begin
      checks++;
      if (obs_a[k] !== 16'h0000 || obs_b[k] !== exp_b[k] || obs_cin[k] !== k[0]) begin
        failures++;
        $display("FAIL stuck_vec%0d: a=%h b=%h cin=%b expected 0000/%h/%b", k, obs_a[k], obs_b[k], obs_cin[k], exp_b[k], k[0]);
      end
    end
    // Golden sums 0001,0004,0006,000E,001B,0037,006D,00DC: four odd ones.
    checks++;
    if (cyc !== 9 || pass !== 1'b0 || err_count !== 16'd4 || first_fail !== 16'd0) begin
      failures++;
      $display("FAIL stuck_result: cyc=%0d pass=%b err=%h ff=%h expected 9/0/0004/0000", cyc, pass, err_count, first_fail);
    end
  endtask

  task automatic test_single_fault();
    int cyc, bc;
    fault_mode = 3;
    run_to_done(16'd8, cyc, bc);
    checks++;
    if (err_count !== 16'd1 || first_fail !== 16'd3 || pass !== 1'b0) begin
      failures++; $display("FAIL single_fault: err=%h ff=%h pass=%b expected 0001/0003/0", err_count, first_fail, pass);
    end
  endtask

  task automatic test_zero_vec();
    int cyc, bc;
    fault_mode = 2;
    run_to_done(16'd0, cyc, bc);
    checks++;
    if (cyc !== 1 || bc !== 0 || done !== 1'b1) begin
      failures++; $display("FAIL zero_timing: cyc=%0d busy_cyc=%0d done=%b expected 1/0/1", cyc, bc, done);
    end
    checks++;
    if (pass !== 1'b1 || err_count !== 16'd0 || first_fail !== 16'hFFFF) begin
      failures++; $display("FAIL zero_result: pass=%b err=%h ff=%h expected 1/0000/ffff", pass, err_count, first_fail);
    end
    // Operands stay at the last vector of the previous 8-vector run.
    checks++;
    if (dut_a !== 16'h0000 || dut_b !== 16'h00DB || dut_cin !== 1'b1) begin
      failures++; $display("FAIL zero_hold: a=%h b=%h cin=%b expected 0000/00db/1", dut_a, dut_b, dut_cin);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bc;
    fault_mode = 0;
    start = 1'b1; num_vec = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || dut_b !== 16'h000D) begin
      failures++; $display("FAIL midrun_vec3: busy=%b b=%h expected 1/000d", busy, dut_b);
    end
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    checks++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
        dut_a !== 16'd0 || dut_b !== 16'd0 || dut_cin !== 1'b0 ||
        err_count !== 16'd0 || first_fail !== 16'hFFFF) begin
      failures++;
      $display("FAIL midrun_reset: st=%0d busy=%b done=%b b=%h err=%h ff=%h expected idle/0/0/0000/0000/ffff",
               state_dbg, busy, done, dut_b, err_count, first_fail);
    end
    @(posedge clk); #1;
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++; $display("FAIL midrun_stay_idle: st=%0d expected 0", state_dbg);
    end
    run_to_done(16'd10, cyc, bc);
    checks++;
    if (cyc !== 11 || bc !== 10 || pass !== 1'b1) begin
      failures++; $display("FAIL midrun_rerun: cyc=%0d busy_cyc=%0d pass=%b expected 11/10/1", cyc, bc, pass);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs_b[k] !== exp_b[k] || obs_cin[k] !== k[0]) begin
        failures++; $display("FAIL rerun_vec%0d: b=%h cin=%b expected %h/%b", k, obs_b[k], obs_cin[k], exp_b[k], k[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    fault_mode = 1;
    start = 1'b1; num_vec = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    @(posedge clk); #1;
    cyc++;
    // start and a smaller num_vec while running must not disturb the run.
    start = 1'b1; num_vec = 16'd2;
    checks++;
    if (pass !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_running: pass=%b busy=%b expected 0/1", pass, busy);
    end
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 5 || err_count !== 16'd1 || first_fail !== 16'd0) begin
      failures++; $display("FAIL b2b_first_run: cyc=%0d err=%h ff=%h expected 5/0001/0000", cyc, err_count, first_fail);
    end
    fault_mode = 0;
    start = 1'b1; num_vec = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || dut_b !== 16'h0001 || dut_cin !== 1'b0 || err_count !== 16'd0 ||
        first_fail !== 16'hFFFF || pass !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b b=%h cin=%b err=%h ff=%h pass=%b expected 1/0001/0/0000/ffff/0",
               busy, dut_b, dut_cin, err_count, first_fail, pass);
    end
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 4 || pass !== 1'b1) begin
      failures++; $display("FAIL b2b_second_run: cyc=%0d pass=%b expected 4/1", cyc, pass);
    end
  endtask

  task automatic test_saturate();
    int cyc, bc;
    fault_mode = 2;
    run_to_done(16'hFFFF, cyc, bc);
    checks++;
    if (cyc !== 65536 || bc !== 65535 || done !== 1'b1) begin
      failures++; $display("FAIL sat_timing: cyc=%0d busy_cyc=%0d done=%b expected 65536/65535/1", cyc, bc, done);
    end
    checks++;
    if (err_count !== 16'hFFFF || first_fail !== 16'd0 || pass !== 1'b0) begin
      failures++; $display("FAIL sat_result: err=%h ff=%h pass=%b expected ffff/0000/0", err_count, first_fail, pass);
    end
  endtask

  initial begin
    checks = 0; failures = 0; fault_mode = 0;
    rst_n = 1'b0; start = 1'b0; num_vec = 16'd0;
    exp_b[0] = 16'h0001; exp_b[1] = 16'h0003; exp_b[2] = 16'h0006; exp_b[3] = 16'h000D;
    exp_b[4] = 16'h001B; exp_b[5] = 16'h0036; exp_b[6] = 16'h006D; exp_b[7] = 16'h00DB;
    test_reset();
    test_basic();
    test_stuck_bit0();
    test_single_fault();
    test_zero_vec();
    test_reset_mid_run();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter: SEED, 32'h0000_0001, initial LFSR state; value 0 SHALL be replaced by 32'h0000_0001.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  begin a test run; sampled only in IDLE and DONE.
REQ-005 num_vec  input  16  vectors to apply; sampled with start.
REQ-006 dut_a  output  16  operand A driven to the adder under test.
REQ-007 dut_b  output  16  operand B driven to the adder under test.
REQ-008 dut_cin  output  1  carry-in driven to the adder under test.
REQ-009 dut_sum  input  16  sum returned by the adder (combinational DUT).
REQ-010 dut_cout  input  1  carry-out returned by the adder.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  valid when done: 1 iff err_count == 0.
REQ-014 err_count  output  16  mismatches in current/last run, saturating at 16'hFFFF.
REQ-015 first_fail  output  16  index of first mismatching vector; 16'hFFFF if none.

Function
REQ-016 States SHALL be IDLE, RUN, DONE; encoding free.
REQ-017 LFSR: 32-bit Fibonacci, shift left, feedback bit = l[31]^l[21]^l[1]^l[0] into l[0]; advances once per RUN cycle.
REQ-018 Vector k: dut_a = lfsr[31:16], dut_b = lfsr[15:0], dut_cin = k[0], where lfsr is the LFSR state after k advances from SEED.
REQ-019 dut_a/dut_b/dut_cin and golden {gcout,gsum} = dut_a + dut_b + dut_cin (17-bit, no truncation) SHALL be registered together.
REQ-020 IDLE/DONE with start=1 and num_vec!=0: next edge -> RUN, vector 0 driven, index=0, LFSR reloaded from SEED, err_count=0, first_fail=16'hFFFF.
REQ-021 IDLE/DONE with start=1 and num_vec==0: next edge -> DONE, pass=1, err_count=0, first_fail=16'hFFFF, outputs to DUT unchanged.
REQ-022 RUN, every edge: compare {dut_cout,dut_sum} with registered golden of currently driven vector; mismatch increments err_count (saturating) and sets first_fail=index if first_fail==16'hFFFF.
REQ-023 RUN, same edge: if index == num_vec-1 -> DONE, drive registers hold; else index+1, next vector loaded.
REQ-024 done SHALL rise exactly num_vec+1 cycles after the edge sampling start; busy high exactly num_vec cycles.
REQ-025 start in RUN SHALL be ignored; num_vec changes in RUN SHALL be ignored (latched copy used).
REQ-026 DONE SHALL hold results until a new start; start in DONE restarts per REQ-020/021.
REQ-027 index SHALL be 16 bits; num_vec=16'hFFFF runs 65535 vectors without wrap.
REQ-028 pass SHALL be 0 outside DONE.

Reset
REQ-029 rst_n=0 at an edge: state=IDLE, dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, err_count=0, first_fail=16'hFFFF, LFSR=SEED, index=0.
REQ-030 Reset mid-RUN SHALL abort the run with no result retained; start in the reset cycle ignored.

Verification
REQ-031 SEED=1, ideal adder, start with num_vec=4 -> first vector A=16'h0000, B=16'h0001, Cin=0; busy 4 cycles; done 5 cycles after start; pass=1, err_count=0, first_fail=16'hFFFF.
REQ-032 Adder with sum bit 0 stuck at 0, num_vec=8 -> pass=0, err_count>=1, first_fail = first index whose golden sum[0]=1 (index 0 for SEED=1).
REQ-033 num_vec=0 with start -> done next cycle, pass=1, busy never asserted.
REQ-034 Adder always wrong, num_vec=16'hFFFF -> err_count=16'hFFFF (saturated), first_fail=0, done after 65536 cycles.
REQ-035 rst_n low for one cycle at vector 3 of a 10-vector run -> IDLE, all outputs at reset values; subsequent start completes a full 10-vector run from vector 0.
REQ-036 start pulsed during RUN and in DONE -> RUN unaffected; DONE restart begins at vector 0 with counters cleared.
